// File: rtl/rfsoc_config_pkg.sv
// rfsoc_config: GPIO bit map of rfsoc_pl_ctrl plus configuration target codes
package rfsoc_config;

    localparam int config_reg_width = 16;

    localparam logic [3:0] sdata                   = 4'd0;
    localparam logic [3:0] trigger_line            = 4'd1;
    localparam logic [3:0] cycle_count_clk         = 4'd2;
    localparam logic [3:0] mask_clk                = 4'd3;
    localparam logic [3:0] pre_delay_clk           = 4'd4;
    localparam logic [3:0] post_delay_clk          = 4'd5;
    localparam logic [3:0] locking_waveform_clk    = 4'd6;
    localparam logic [3:0] mux_set_clk             = 4'd7;
    localparam logic [3:0] mask_enable_clk         = 4'd8;
    localparam logic [3:0] channel_sel_clk         = 4'd9;
    localparam logic [3:0] adc_num_cycle_count_clk = 4'd10;
    localparam logic [3:0] adc_shift_val_clk       = 4'd11;

    typedef enum logic [3:0] {
        CFG_CYCLE_COUNT         = 4'd0,
        CFG_MASK                = 4'd1,
        CFG_PRE_DELAY           = 4'd2,
        CFG_POST_DELAY          = 4'd3,
        CFG_LOCKING_WAVEFORM    = 4'd4,
        CFG_MUX_SET             = 4'd5,
        CFG_MASK_ENABLE         = 4'd6,
        CFG_CHANNEL_SEL         = 4'd7,
        CFG_ADC_NUM_CYCLE_COUNT = 4'd8,
        CFG_ADC_SHIFT_VAL       = 4'd9
    } cfg_target_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_HOLD} ser_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } cfg_map_t;

    // Codes outside cfg_target_t, or landing on the data/trigger lines, are invalid
    function automatic cfg_map_t cfg_target_to_bit(input logic [3:0] code);
        cfg_map_t m;
        m.valid = 1'b1;
        case (code)
            CFG_CYCLE_COUNT:         m.idx = cycle_count_clk;
            CFG_MASK:                m.idx = mask_clk;
            CFG_PRE_DELAY:           m.idx = pre_delay_clk;
            CFG_POST_DELAY:          m.idx = post_delay_clk;
            CFG_LOCKING_WAVEFORM:    m.idx = locking_waveform_clk;
            CFG_MUX_SET:             m.idx = mux_set_clk;
            CFG_MASK_ENABLE:         m.idx = mask_enable_clk;
            CFG_CHANNEL_SEL:         m.idx = channel_sel_clk;
            CFG_ADC_NUM_CYCLE_COUNT: m.idx = adc_num_cycle_count_clk;
            CFG_ADC_SHIFT_VAL:       m.idx = adc_shift_val_clk;
            default: begin
                m.valid = 1'b0;
                m.idx   = sdata;
            end
        endcase
        m.valid = m.valid && (m.idx != sdata) && (m.idx != trigger_line);
        return m;
    endfunction

endpackage

// File: rtl/gpio_cfg_serializer.sv
// gpio_cfg_serializer: shifts one configuration command LSB first onto the GPIO bus
module gpio_cfg_serializer
    import rfsoc_config::*;
#(
    parameter int DATA_W       = 256,
    parameter int SETUP_CYCLES = 2,
    parameter int HIGH_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                        i_ps_clk,
    input  logic                        i_rst,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [3:0]                  i_cmd_target,
    input  logic [8:0]                  i_cmd_len,
    input  logic [DATA_W-1:0]           i_cmd_data,
    input  logic                        i_trig_req,
    output logic [config_reg_width-1:0] o_gpio_ctrl,
    output logic                        o_done,
    output logic                        o_cmd_err
);

    localparam int PH_MAX = (SETUP_CYCLES > HIGH_CYCLES)
                          ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                          : ((HIGH_CYCLES > HOLD_CYCLES) ? HIGH_CYCLES : HOLD_CYCLES);
    localparam int PH_W = $clog2(PH_MAX + 1);

    ser_state_t                  r_state, w_next;
    logic [PH_W-1:0]             r_phase, w_lim;
    logic [8:0]                  r_bits, w_len;
    logic [DATA_W-1:0]           r_data;
    logic [3:0]                  r_idx;
    logic                        r_done, r_err, r_trig;
    logic                        w_ph_end, w_load, w_quick, w_shift, w_finish;
    logic [config_reg_width-1:0] w_gpio;
    cfg_map_t                    w_map;

    assign w_map       = cfg_target_to_bit(i_cmd_target);
    assign w_len       = (i_cmd_len > 9'(DATA_W)) ? 9'(DATA_W) : i_cmd_len;
    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_done      = r_done;
    assign o_cmd_err   = r_err;
    assign o_gpio_ctrl = w_gpio;

    // State register; reset drops any command in flight and forces the shift clock low
    always_ff @(posedge i_ps_clk) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and the strobes that steer the datapath
    always_comb begin
        w_lim    = (r_state == ST_SETUP) ? PH_W'(SETUP_CYCLES - 1)
                 : (r_state == ST_HIGH)  ? PH_W'(HIGH_CYCLES - 1)
                 :                         PH_W'(HOLD_CYCLES - 1);
        w_ph_end = (r_phase == w_lim);
        w_load   = (r_state == ST_IDLE) && i_cmd_valid && w_map.valid && (w_len != 9'd0);
        w_quick  = (r_state == ST_IDLE) && i_cmd_valid && !(w_map.valid && (w_len != 9'd0));
        w_shift  = (r_state == ST_HOLD) && w_ph_end && (r_bits != 9'd1);
        w_finish = (r_state == ST_HOLD) && w_ph_end && (r_bits == 9'd1);
        w_next   = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_load ? ST_SETUP : ST_IDLE;
            ST_SETUP: w_next = w_ph_end ? ST_HIGH : ST_SETUP;
            ST_HIGH:  w_next = w_ph_end ? ST_HOLD : ST_HIGH;
            ST_HOLD:  w_next = w_finish ? ST_IDLE : (w_shift ? ST_SETUP : ST_HOLD);
            default:  w_next = ST_IDLE;
        endcase
    end

    // Payload, bit and phase counters; bit 0 of the shifter is the live sdata value
    always_ff @(posedge i_ps_clk) begin
        if (!i_rst) begin
            r_phase <= '0;
            r_bits  <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_phase <= (r_state == ST_IDLE || w_next != r_state) ? '0 : r_phase + 1'b1;
            r_done  <= w_quick || w_finish;
            r_err   <= w_quick && !w_map.valid;
            if (w_load) begin
                r_data <= i_cmd_data;
                r_bits <= w_len;
                r_idx  <= w_map.idx;
            end else if (w_shift) begin
                r_data <= r_data >> 1;
                r_bits <= r_bits - 9'd1;
            end
        end
    end

    // Trigger is a one-cycle delayed copy of the request, independent of the shifter
    always_ff @(posedge i_ps_clk) begin
        if (!i_rst) r_trig <= 1'b0;
        else        r_trig <= i_trig_req;
    end

    // Only sdata, trigger and the latched target clock may ever be non-zero
    always_comb begin
        w_gpio               = '0;
        w_gpio[sdata]        = r_data[0];
        w_gpio[trigger_line] = r_trig;
        if (r_state == ST_HIGH) w_gpio[r_idx] = 1'b1;
    end

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// tb_gpio_cfg_serializer: directed checks of shift timing, targets, errors, reset and trigger
module tb_gpio_cfg_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_target;
    logic [8:0]   cmd_len;
    logic [255:0] cmd_data;
    logic         trig_req;
    logic [15:0]  gpio;
    logic         done;
    logic         cmd_err;

    int passed = 0;
    int total  = 0;

    gpio_cfg_serializer dut (
        .i_ps_clk    (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_target(cmd_target),
        .i_cmd_len   (cmd_len),
        .i_cmd_data  (cmd_data),
        .i_trig_req  (trig_req),
        .o_gpio_ctrl (gpio),
        .o_done      (done),
        .o_cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issues one command and watches the bus until done; target code k drives gpio bit k+2
    task automatic run_cmd(input logic [3:0] tgt, input logic [8:0] len, input logic [255:0] data,
                           input int trig_at, output int cyc, output int pulses, output int first_rise,
                           output logic [255:0] cap, output logic stray, output int trig_cnt,
                           output int trig_first, output logic busy_ok);
        logic        prev;
        logic [15:0] allow;
        int          idx;
        idx = int'(tgt) + 2;
        allow = 16'h0003 | (16'h0001 << idx);
        cyc = -1; pulses = 0; first_rise = -1; cap = '0; stray = 1'b0;
        trig_cnt = 0; trig_first = -1;
        cmd_valid = 1'b1; cmd_target = tgt; cmd_len = len; cmd_data = data;
        tick();
        cmd_valid = 1'b0;
        busy_ok = !cmd_ready;
        prev = gpio[idx];
        for (int t = 1; t <= 2000; t++) begin
            trig_req = (t - 1 == trig_at);
            tick();
            if ((gpio & ~allow) != 16'h0) stray = 1'b1;
            if (gpio[idx] && !prev) begin
                if (first_rise < 0) first_rise = t;
                if (pulses < 256) cap[pulses] = gpio[0];
                pulses++;
            end
            prev = gpio[idx];
            if (gpio[1]) begin
                trig_cnt++;
                if (trig_first < 0) trig_first = t;
            end
            if (!done && cmd_ready) busy_ok = 1'b0;
            if (done) begin
                cyc = t;
                break;
            end
        end
        trig_req = 1'b0;
    endtask

    int           cyc, pulses, first_rise, trig_cnt, trig_first;
    logic [255:0] cap, mask_data;
    logic         stray, busy_ok, saw_done;
    logic [15:0]  gpio_before;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_len = '0; cmd_data = '0; trig_req = 1'b0;
        tick();
        tick();
        check("rst_gpio", gpio, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_err", cmd_err, 0);
        rst = 1'b1;
        tick();

        // cycle_count: data 10, 16 bits
        run_cmd(4'd0, 9'd16, 256'd10, -1, cyc, pulses, first_rise, cap, stray, trig_cnt, trig_first, busy_ok);
        check("cc_cycles", cyc, 96);
        check("cc_pulses", pulses, 16);
        check("cc_first_rise", first_rise, 2);
        check("cc_sdata", cap, 256'd10);
        check("cc_stray", stray, 0);
        check("cc_busy", busy_ok, 1);
        check("cc_err", cmd_err, 0);

        // channel_sel: one-hot channel 5
        run_cmd(4'd7, 9'd16, 256'd32, -1, cyc, pulses, first_rise, cap, stray, trig_cnt, trig_first, busy_ok);
        check("ch_cycles", cyc, 96);
        check("ch_pulses", pulses, 16);
        check("ch_sdata", cap, 256'd32);
        check("ch_stray", stray, 0);

        // mask: low 128 bits ones, full width
        mask_data = {128'h0, {128{1'b1}}};
        run_cmd(4'd1, 9'd256, mask_data, -1, cyc, pulses, first_rise, cap, stray, trig_cnt, trig_first, busy_ok);
        check("mask_cycles", cyc, 1536);
        check("mask_pulses", pulses, 256);
        check("mask_sdata", cap, mask_data);
        check("mask_stray", stray, 0);

        // oversize length clamps to 256 bits
        run_cmd(4'd6, 9'd300, 256'd1, -1, cyc, pulses, first_rise, cap, stray, trig_cnt, trig_first, busy_ok);
        check("clamp_cycles", cyc, 1536);
        check("clamp_pulses", pulses, 256);

        // back-to-back: second command held valid through the done cycle
        cmd_valid = 1'b1; cmd_target = 4'd0; cmd_len = 9'd1; cmd_data = 256'd1;
        tick();
        for (int t = 1; t <= 6; t++) tick();
        check("b2b_done", done, 1);
        check("b2b_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("b2b_busy", cmd_ready, 0);
        tick();
        check("b2b_clk_low", gpio[2], 0);
        tick();
        check("b2b_clk_high", gpio[2], 1);
        for (int t = 10; t <= 13; t++) tick();
        check("b2b_done2", done, 1);
        tick();

        // zero-length command
        gpio_before = gpio;
        cmd_valid = 1'b1; cmd_target = 4'd2; cmd_len = 9'd0; cmd_data = 256'hFFFE;
        tick();
        cmd_valid = 1'b0;
        check("len0_done", done, 1);
        check("len0_err", cmd_err, 0);
        check("len0_gpio", gpio, gpio_before);
        tick();
        check("len0_done_pulse", done, 0);

        // invalid target code 15
        cmd_valid = 1'b1; cmd_target = 4'd15; cmd_len = 9'd8; cmd_data = 256'hFE;
        tick();
        cmd_valid = 1'b0;
        check("inv_done", done, 1);
        check("inv_err", cmd_err, 1);
        check("inv_gpio", gpio, gpio_before);
        tick();
        check("inv_done_pulse", done, 0);

        // reset during the high phase of bit 3
        cmd_valid = 1'b1; cmd_target = 4'd0; cmd_len = 9'd16; cmd_data = 256'hFFFF;
        tick();
        cmd_valid = 1'b0;
        for (int t = 1; t <= 20; t++) tick();
        check("rstmid_clk_high", gpio[2], 1);
        rst = 1'b0;
        tick();
        check("rstmid_gpio", gpio, 0);
        check("rstmid_ready", cmd_ready, 1);
        check("rstmid_done", done, 0);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("rstmid_no_done", saw_done, 0);
        run_cmd(4'd3, 9'd16, 256'hA5C3, -1, cyc, pulses, first_rise, cap, stray, trig_cnt, trig_first, busy_ok);
        check("post_rst_cycles", cyc, 96);
        check("post_rst_sdata", cap, 256'hA5C3);
        check("post_rst_stray", stray, 0);

        // trigger during an active shift
        run_cmd(4'd2, 9'd4, 256'h6, 3, cyc, pulses, first_rise, cap, stray, trig_cnt, trig_first, busy_ok);
        check("trig_count", trig_cnt, 1);
        check("trig_first", trig_first, 4);
        check("trig_cycles", cyc, 24);
        check("trig_pulses", pulses, 4);
        check("trig_sdata", cap, 256'h6);
        check("trig_stray", stray, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
